// File: rtl/adc_frame_sync_if.sv
// Sample-stream and framing-status bundle for adc_frame_sync.
// master drives the sample stream; slave is the frame synchroniser.
interface adc_frame_sync_if;
  logic [13:0] in_data;
  logic        in_valid;
  logic [13:0] out_data;
  logic        out_valid;
  logic [7:0]  out_idx;
  logic        frame_start;
  logic        frame_end;
  logic        locked;
  logic        sync_lost;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  modport master (
    output in_data, in_valid,
    input  out_data, out_valid, out_idx, frame_start, frame_end,
    input  locked, sync_lost, frame_cnt, err_cnt
  );

  modport slave (
    input  in_data, in_valid,
    output out_data, out_valid, out_idx, frame_start, frame_end,
    output locked, sync_lost, frame_cnt, err_cnt
  );
endinterface

// File: rtl/adc_frame_sync.sv
// Locks onto a gap/payload ADC test stream and forwards indexed payload samples.
// Optional frame/error counters are built only when ADC_FRAME_SYNC_STATS_EN is defined.
module adc_frame_sync #(
  parameter int          GAP_LEN     = 16,
  parameter int          GAP_MIN     = 12,
  parameter int          PAYLOAD_LEN = 256,
  parameter logic [13:0] THRESH      = 14'd2048
) (
  input  logic             clk,
  input  logic             rst,
  adc_frame_sync_if.slave  bus
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] GAP     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] GAPCHK  = 2'd3;

  localparam int RUN_MAX = (GAP_LEN > GAP_MIN) ? GAP_LEN : GAP_MIN;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
  localparam logic [RUN_W-1:0] GAP_MIN_M1 = RUN_W'(GAP_MIN - 1);
  localparam logic [RUN_W-1:0] GAP_LEN_C  = RUN_W'(GAP_LEN);
  localparam logic [7:0]       LAST_M1    = 8'(PAYLOAD_LEN - 2);

  logic [1:0]       state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic [13:0]      out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic [7:0]       out_idx_reg, out_idx_next;
  logic             frame_start_reg, frame_start_next;
  logic             frame_end_reg, frame_end_next;
  logic             locked_reg, locked_next;
  logic             sync_lost_reg, sync_lost_next;
  logic             is_low, start_frame, lose_sync;

  assign is_low = (bus.in_data < THRESH);

  always_comb begin
    state_next       = state_reg;
    run_next         = run_reg;
    out_data_next    = out_data_reg;
    out_valid_next   = 1'b0;
    out_idx_next     = out_idx_reg;
    frame_start_next = 1'b0;
    frame_end_next   = 1'b0;
    locked_next      = locked_reg;
    sync_lost_next   = 1'b0;
    start_frame      = 1'b0;
    lose_sync        = 1'b0;

    if (bus.in_valid) begin
      case (state_reg)
        SEARCH: begin
          if (!is_low) begin
            run_next = '0;
          end else if (run_reg == GAP_MIN_M1) begin
            state_next = GAP;
            run_next   = '0;
          end else begin
            run_next = run_reg + RUN_ONE;
          end
        end
        GAP: begin
          if (!is_low) start_frame = 1'b1;
        end
        PAYLOAD: begin
          if (is_low) begin
            lose_sync = 1'b1;
            run_next  = RUN_ONE;
          end else begin
            out_valid_next = 1'b1;
            out_data_next  = bus.in_data;
            out_idx_next   = out_idx_reg + 8'd1;
            if (out_idx_reg == LAST_M1) begin
              frame_end_next = 1'b1;
              state_next     = GAPCHK;
              run_next       = '0;
            end
          end
        end
        default: begin
          // GAPCHK: run_reg counts gap lows since the last frame_end
          if (is_low) begin
            if (run_reg == GAP_LEN_C) begin
              lose_sync = 1'b1;
              run_next  = RUN_ONE;
            end else begin
              run_next = run_reg + RUN_ONE;
            end
          end else if (run_reg == GAP_LEN_C) begin
            start_frame = 1'b1;
          end else begin
            lose_sync = 1'b1;
            run_next  = '0;
          end
        end
      endcase
    end

    if (start_frame) begin
      state_next       = PAYLOAD;
      out_valid_next   = 1'b1;
      out_data_next    = bus.in_data;
      out_idx_next     = 8'd0;
      frame_start_next = 1'b1;
      locked_next      = 1'b1;
    end
    if (lose_sync) begin
      state_next     = SEARCH;
      sync_lost_next = 1'b1;
      locked_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= SEARCH;
      run_reg         <= '0;
      out_data_reg    <= '0;
      out_valid_reg   <= 1'b0;
      out_idx_reg     <= '0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
      locked_reg      <= 1'b0;
      sync_lost_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      run_reg         <= run_next;
      out_data_reg    <= out_data_next;
      out_valid_reg   <= out_valid_next;
      out_idx_reg     <= out_idx_next;
      frame_start_reg <= frame_start_next;
      frame_end_reg   <= frame_end_next;
      locked_reg      <= locked_next;
      sync_lost_reg   <= sync_lost_next;
    end
  end

  assign bus.out_data    = out_data_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_idx     = out_idx_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.frame_end   = frame_end_reg;
  assign bus.locked      = locked_reg;
  assign bus.sync_lost   = sync_lost_reg;

`ifdef ADC_FRAME_SYNC_STATS_EN
  logic [15:0] frame_cnt_reg, err_cnt_reg;

  // Counters advance on the same edge as their pulses and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      if (frame_end_next) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if (sync_lost_next) err_cnt_reg   <= err_cnt_reg + 16'd1;
    end
  end

  assign bus.frame_cnt = frame_cnt_reg;
  assign bus.err_cnt   = err_cnt_reg;
`else
  assign bus.frame_cnt = '0;
  assign bus.err_cnt   = '0;
`endif

endmodule

// File: tb/tb_adc_frame_sync.sv
// Randomised scoreboard bench for adc_frame_sync against a sample-by-sample framing model.
// Build with or without ADC_FRAME_SYNC_STATS_EN; counter expectations follow the macro.
module tb_adc_frame_sync;
  localparam int          GAP_LEN     = 16;
  localparam int          GAP_MIN     = 12;
  localparam int          PAYLOAD_LEN = 256;
  localparam logic [13:0] THRESH      = 14'd2048;
`ifdef ADC_FRAME_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   obs_ov = 0, obs_fs = 0, obs_fe = 0, obs_sl = 0;

  adc_frame_sync_if bus ();

  adc_frame_sync #(
    .GAP_LEN(GAP_LEN), .GAP_MIN(GAP_MIN), .PAYLOAD_LEN(PAYLOAD_LEN), .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    logic [13:0] dat;
    logic        ov;
    logic [7:0]  idx;
    logic        fs, fe, lk, sl;
    logic [15:0] fc, ec;
  } exp_t;
  exp_t q[$];

  // Reference model: where are we in the gap/payload pattern, and what has been emitted.
  typedef enum int {HUNT, ARMED, DATA, CHECK} mode_t;
  mode_t       mode = HUNT;
  int          hunt_lows = 0, pos = 0, gap_lows = 0;
  logic [13:0] m_dat = '0;
  logic [7:0]  m_idx = '0;
  logic        m_lk = 1'b0;
  logic [15:0] m_frames = '0, m_errs = '0;

  task automatic model_step(input logic r, input logic v, input logic [13:0] d, output exp_t e);
    bit low;
    e.ov = 0; e.fs = 0; e.fe = 0; e.sl = 0;
    if (r) begin
      mode = HUNT; hunt_lows = 0; m_dat = '0; m_idx = '0; m_lk = 0;
      m_frames = '0; m_errs = '0;
    end else if (v) begin
      low = (d < THRESH);
      if (mode == HUNT) begin
        hunt_lows = low ? hunt_lows + 1 : 0;
        if (hunt_lows >= GAP_MIN) mode = ARMED;
      end else if (mode == ARMED) begin
        if (!low) begin
          e.ov = 1; e.fs = 1; m_dat = d; m_idx = 0; m_lk = 1; mode = DATA; pos = 1;
        end
      end else if (mode == DATA) begin
        if (low) begin
          e.sl = 1; m_errs++; m_lk = 0; mode = HUNT; hunt_lows = 1;
        end else begin
          e.ov = 1; m_dat = d; m_idx = 8'(pos);
          if (pos == PAYLOAD_LEN - 1) begin
            e.fe = 1; m_frames++; mode = CHECK; gap_lows = 0;
          end else begin
            pos++;
          end
        end
      end else begin
        if (low && gap_lows < GAP_LEN) begin
          gap_lows++;
        end else if (!low && gap_lows == GAP_LEN) begin
          e.ov = 1; e.fs = 1; m_dat = d; m_idx = 0; mode = DATA; pos = 1;
        end else begin
          e.sl = 1; m_errs++; m_lk = 0; mode = HUNT; hunt_lows = low ? 1 : 0;
        end
      end
    end
    e.dat = m_dat; e.idx = m_idx; e.lk = m_lk;
    e.fc = STATS ? m_frames : 16'd0;
    e.ec = STATS ? m_errs : 16'd0;
  endtask

  task automatic drive(input logic r, input logic v, input logic [13:0] d);
    exp_t e;
    @(posedge clk); #1;
    rst = r; bus.in_valid = v; bus.in_data = d;
    model_step(r, v, d, e);
    e.stamp = cyc + 1;
    q.push_back(e);
  endtask

  task automatic send(input logic [13:0] d, input int pct);
    while (int'($urandom_range(99, 0)) < pct) drive(1'b0, 1'b0, 14'($urandom));
    drive(1'b0, 1'b1, d);
  endtask

  function automatic logic [13:0] low_sample(input bit rnd);
    if (!rnd) return 14'd0;
    return ($urandom_range(1, 0) == 1) ? THRESH - 14'd1 : 14'($urandom_range(THRESH - 1, 0));
  endfunction

  task automatic gap(input int n, input int pct, input bit rnd);
    for (int i = 0; i < n; i++) send(low_sample(rnd), pct);
  endtask

  task automatic payload(input int first, input int last, input int pct, input int glitch, input bit rnd);
    logic [13:0] d;
    for (int k = first; k <= last; k++) begin
      d = rnd ? 14'($urandom_range(16383, THRESH)) : 14'(4096 + 48 * k);
      if (k == glitch) d = 14'd0;
      send(d, pct);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 14'd0);
    drive(1'b1, 1'b1, 14'd5000);
    drive(1'b0, 1'b0, 14'd0);
    @(negedge clk); #1;
    obs_ov = 0; obs_fs = 0; obs_fe = 0; obs_sl = 0;
  endtask

  task automatic settle();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].stamp < cyc) begin
      checks++; errors++;
      $display("FAIL sb_missed: expectation for cycle %0d never compared (now %0d)", q[0].stamp, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].stamp == cyc) begin
      me = q.pop_front();
      checks++;
      if (bus.out_data !== me.dat || bus.out_valid !== me.ov || bus.out_idx !== me.idx ||
          bus.frame_start !== me.fs || bus.frame_end !== me.fe || bus.locked !== me.lk ||
          bus.sync_lost !== me.sl || bus.frame_cnt !== me.fc || bus.err_cnt !== me.ec) begin
        errors++;
        $display("FAIL sb_cycle %0d: got dat=%0d v=%b idx=%0d fs=%b fe=%b lk=%b sl=%b fc=%0d ec=%0d, want dat=%0d v=%b idx=%0d fs=%b fe=%b lk=%b sl=%b fc=%0d ec=%0d",
                 cyc, bus.out_data, bus.out_valid, bus.out_idx, bus.frame_start, bus.frame_end,
                 bus.locked, bus.sync_lost, bus.frame_cnt, bus.err_cnt,
                 me.dat, me.ov, me.idx, me.fs, me.fe, me.lk, me.sl, me.fc, me.ec);
      end
      checks++;
      if ((bus.out_valid === 1'b1 && bus.sync_lost === 1'b1) ||
          (bus.frame_start === 1'b1 && bus.frame_end === 1'b1)) begin
        errors++;
        $display("FAIL exclusive_pulses cycle %0d: ov=%b sl=%b fs=%b fe=%b, want no overlap",
                 cyc, bus.out_valid, bus.sync_lost, bus.frame_start, bus.frame_end);
      end
      if (bus.out_valid === 1'b1)   obs_ov++;
      if (bus.frame_start === 1'b1) obs_fs++;
      if (bus.frame_end === 1'b1)   obs_fe++;
      if (bus.sync_lost === 1'b1)   obs_sl++;
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Nominal: three frames
    do_reset();
    for (int f = 0; f < 3; f++) begin
      gap(GAP_LEN, 0, 0);
      payload(0, PAYLOAD_LEN - 1, 0, -1, 0);
    end
    settle();
    chk("nominal_frame_start", obs_fs, 3);
    chk("nominal_out_valid", obs_ov, 3 * PAYLOAD_LEN);
    chk("nominal_frame_end", obs_fe, 3);
    chk("nominal_frame_cnt", int'(bus.frame_cnt), STATS ? 3 : 0);
    chk("nominal_err_cnt", int'(bus.err_cnt), 0);

    // Stream joined mid-payload
    do_reset();
    payload(100, PAYLOAD_LEN - 1, 0, -1, 0);
    settle();
    chk("midstart_no_output", obs_ov, 0);
    gap(GAP_LEN, 0, 0);
    payload(0, PAYLOAD_LEN - 1, 0, -1, 0);
    settle();
    chk("midstart_one_frame", obs_ov, PAYLOAD_LEN);

    // Payload glitch at sample 57, then relock
    do_reset();
    gap(GAP_LEN, 0, 0);
    payload(0, PAYLOAD_LEN - 1, 0, -1, 0);
    gap(GAP_LEN, 0, 0);
    payload(0, PAYLOAD_LEN - 1, 0, 57, 0);
    settle();
    chk("glitch_sync_lost", obs_sl, 1);
    chk("glitch_unlocked", int'(bus.locked), 0);
    chk("glitch_err_cnt", int'(bus.err_cnt), STATS ? 1 : 0);
    gap(GAP_LEN, 0, 0);
    payload(0, 10, 0, -1, 0);
    settle();
    chk("glitch_relock", int'(bus.locked), 1);

    // Gap shortened to GAP_LEN-1
    do_reset();
    gap(GAP_LEN, 0, 0);
    payload(0, PAYLOAD_LEN - 1, 0, -1, 0);
    gap(GAP_LEN - 1, 0, 0);
    payload(0, PAYLOAD_LEN - 1, 0, -1, 0);
    settle();
    chk("shortgap_frame_start", obs_fs, 1);
    chk("shortgap_sync_lost", obs_sl, 1);
    chk("shortgap_err_cnt", int'(bus.err_cnt), STATS ? 1 : 0);

    // Bubbles across two frames
    do_reset();
    for (int f = 0; f < 2; f++) begin
      gap(GAP_LEN, 30, 0);
      payload(0, PAYLOAD_LEN - 1, 30, -1, 0);
    end
    settle();
    chk("bubble_out_valid", obs_ov, 2 * PAYLOAD_LEN);
    chk("bubble_frame_cnt", int'(bus.frame_cnt), STATS ? 2 : 0);

    // Reset at out_idx 200 overriding a valid sample, then relock
    do_reset();
    gap(GAP_LEN, 0, 0);
    payload(0, 200, 0, -1, 0);
    drive(1'b1, 1'b1, 14'd9000);
    settle();
    chk("rst_mid_idx", int'(bus.out_idx), 0);
    chk("rst_mid_locked", int'(bus.locked), 0);
    payload(201, PAYLOAD_LEN - 1, 0, -1, 0);
    gap(GAP_LEN, 0, 0);
    payload(0, PAYLOAD_LEN - 1, 0, -1, 0);
    settle();
    chk("rst_mid_frame_end", obs_fe, 1);
    chk("rst_mid_frame_cnt", int'(bus.frame_cnt), STATS ? 1 : 0);

    // Random gaps, glitches, threshold-edge samples and bubbles
    do_reset();
    for (int f = 0; f < 8; f++) begin
      gap(int'($urandom_range(GAP_LEN + 2, GAP_LEN - 2)), 20, 1);
      send(THRESH, 20);
      payload(1, PAYLOAD_LEN - 1, 20,
              ($urandom_range(3, 0) == 0) ? int'($urandom_range(PAYLOAD_LEN - 1, 1)) : -1, 1);
    end
    settle();
    chk("random_queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_frame_sync.md
ADC_FRAME_SYNC -- requirements
Module: adc_frame_sync

Interface
REQ-001 Parameter GAP_LEN, default 16: number of zero-level gap samples between payload bursts.
REQ-002 Parameter GAP_MIN, default 12: number of consecutive low samples required to declare a gap while searching.
REQ-003 Parameter PAYLOAD_LEN, default 256: number of payload samples per frame.
REQ-004 Parameter THRESH, default 14'd2048: low/high decision level; a sample < THRESH is low, >= THRESH is high.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_data  input  14  test-signal sample stream (16 low gap samples, then 256 samples at 4096..16336).
REQ-008 in_valid  input  1  in_data qualifier; cycles with in_valid=0 SHALL change no state.
REQ-009 out_data  output  14  registered copy of a payload sample.
REQ-010 out_valid  output  1  high for one cycle per forwarded payload sample.
REQ-011 out_idx  output  8  payload index of out_data, 0..PAYLOAD_LEN-1.
REQ-012 frame_start  output  1  one-cycle pulse coincident with out_idx=0.
REQ-013 frame_end  output  1  one-cycle pulse coincident with out_idx=PAYLOAD_LEN-1.
REQ-014 locked  output  1  high while the block is aligned to the frame structure.
REQ-015 sync_lost  output  1  one-cycle pulse on any framing violation while locked.
REQ-016 frame_cnt  output  16  count of completed frames.
REQ-017 err_cnt  output  16  count of sync_lost events.

Function
REQ-018 The block SHALL implement states SEARCH, GAP, PAYLOAD, GAPCHK; only valid samples SHALL advance it.
REQ-019 SEARCH: a run counter SHALL count consecutive low samples, clearing on a high sample; on reaching GAP_MIN the state SHALL become GAP.
REQ-020 GAP: low samples SHALL be absorbed; the first high sample SHALL enter PAYLOAD as index 0, set locked=1 and pulse frame_start.
REQ-021 PAYLOAD: each high sample SHALL be forwarded with out_idx incrementing by 1; the sample at index PAYLOAD_LEN-1 SHALL pulse frame_end, increment frame_cnt and enter GAPCHK.
REQ-022 PAYLOAD: a low sample SHALL not be forwarded; it SHALL pulse sync_lost, increment err_cnt, clear locked, and enter SEARCH with the run counter loaded to 1.
REQ-023 GAPCHK: exactly GAP_LEN low samples SHALL be expected; a high sample after exactly GAP_LEN lows SHALL start the next payload as REQ-020 (locked stays 1).
REQ-024 GAPCHK: a high sample before GAP_LEN lows, or a low sample beyond GAP_LEN, SHALL pulse sync_lost, increment err_cnt, clear locked, enter SEARCH.
REQ-025 All outputs SHALL be registered; latency from in_data sampled to out_data/out_valid SHALL be exactly 1 clk.
REQ-026 frame_cnt and err_cnt SHALL wrap from 16'hFFFF to 0.
REQ-027 frame_end and frame_start SHALL never assert in the same cycle; sync_lost and out_valid SHALL never assert in the same cycle.
REQ-028 out_data SHALL hold its last value when out_valid=0.

Reset
REQ-029 rst=1 SHALL force state SEARCH, run counter 0, out_data=0, out_valid=0, out_idx=0, frame_start=0, frame_end=0, locked=0, sync_lost=0, frame_cnt=0, err_cnt=0 on the next clk edge.
REQ-030 rst asserted mid-payload SHALL abort the frame with no frame_end or sync_lost pulse; rst SHALL override in_valid.

Configuration
REQ-031 Macro ADC_FRAME_SYNC_STATS_EN: defined -> frame_cnt and err_cnt SHALL behave per REQ-021/022/024/026; undefined -> both SHALL be constant 0 and no counter registers SHALL be synthesised; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then 3 nominal frames (16 zeros + 256 samples at 4096+48*k) -> first frame locks, 3 frame_start, 768 out_valid, 3 frame_end, frame_cnt=3, err_cnt=0.
REQ-033 Start stream mid-payload at sample 100 -> no out_valid until after the next 16-zero gap; first forwarded sample has out_idx=0.
REQ-034 Locked, payload sample 57 forced to 0 -> sync_lost at that cycle+1, locked=0, err_cnt=1, relock on the following gap.
REQ-035 Locked, gap shortened to 15 zeros -> sync_lost, err_cnt increments, no frame_start for that payload.
REQ-036 Random in_valid=0 bubbles (~30%) across 2 frames -> identical out_data/out_idx sequence as bubble-free run, frame_cnt=2.
REQ-037 rst pulsed at out_idx=200 -> all outputs 0 next cycle, no frame_end, relock on next gap; with ADC_FRAME_SYNC_STATS_EN undefined frame_cnt=err_cnt=0 throughout.
